logs_freq_meter: RTL

- Receive-side counterpart of the square-wave NCO: takes a square wave (`snd_in`) sampled on `step` ticks and recovers the frequency code that would produce it.
- Measures rising-edge-to-rising-edge period in `step` ticks, then divides 2^N by it with a sequential restoring divider.
- Emits a `freq_out` code in the same units as the NCO's frequency input, plus a one-clock valid strobe.
- Used for self-test loopback of oscillator outputs and for pitch tracking of external square waves.

---
 rtl/logs_freq_meter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/logs_freq_meter.sv
// logs_freq_meter: measures a square wave's rise-to-rise period in step ticks and divides 2^N by it.
// Defining LOGS_FMETER_DEGLITCH_EN adds a two-sample debounce on snd_in.
module logs_freq_meter #(
  parameter int N = 5,
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  logic         snd_in,
  output logic [N-2:0] freq_out,
  output logic         valid,
  output logic         locked
);

  localparam int IW = $clog2(N + 1);
  localparam logic [W-1:0]  CNT_MAX   = '1;
  localparam logic [W-1:0]  CNT_TMO   = CNT_MAX - W'(1);
  localparam logic [N:0]    DIVIDEND  = {1'b1, {N{1'b0}}};
  localparam logic [N-2:0]  FREQ_MAX  = '1;
  localparam logic [IW-1:0] ITER_LAST = IW'(N);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state_reg, state_next;

  logic          s;
  logic          prev_reg;
  logic          first_reg;
  logic [W-1:0]  cnt_reg;
  logic [W:0]    p_reg;
  logic [W:0]    rem_reg;
  logic [W+1:0]  rem_shift;
  logic [W:0]    rem_next;
  logic [N:0]    quo_reg;
  logic [N:0]    dvd_reg;
  logic [IW-1:0] iter_reg;
  logic          q_bit;
  logic          rise;
  logic          timeout;
  logic          accept;
  logic [N-2:0]  freq_sat;

`ifdef LOGS_FMETER_DEGLITCH_EN
  logic s_reg;
  logic pend_reg;

  // A new level is taken on the second consecutive differing sample, so edges lag by one step.
  assign s = (pend_reg && (snd_in != s_reg)) ? snd_in : s_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_reg    <= 1'b0;
      pend_reg <= 1'b0;
    end else if (step) begin
      s_reg    <= s;
      pend_reg <= (snd_in != s_reg) && !pend_reg;
    end
  end
`else
  assign s = snd_in;
`endif

  assign rise    = step & s & ~prev_reg;
  assign timeout = step & ~rise & (cnt_reg == CNT_TMO);
  assign accept  = rise & ~first_reg & (state_reg == IDLE);

  always_comb begin
    rem_shift = {rem_reg, dvd_reg[N]};
    q_bit     = (rem_shift >= {1'b0, p_reg});
    rem_next  = q_bit ? (W+1)'(rem_shift - {1'b0, p_reg}) : rem_shift[W:0];
    freq_sat  = (quo_reg > {2'b00, FREQ_MAX}) ? FREQ_MAX : quo_reg[N-2:0];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = DIV;
      DIV:     if (iter_reg == ITER_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (timeout) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_reg  <= 1'b0;
      first_reg <= 1'b1;
      cnt_reg   <= '0;
      p_reg     <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      dvd_reg   <= '0;
      iter_reg  <= '0;
      freq_out  <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (step) begin
        prev_reg <= s;
        if (rise)                    cnt_reg <= '0;
        else if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + W'(1);
      end
      if (rise) first_reg <= 1'b0;

      if (accept) begin
        p_reg    <= {1'b0, cnt_reg} + (W+1)'(1);
        rem_reg  <= '0;
        quo_reg  <= '0;
        dvd_reg  <= DIVIDEND;
        iter_reg <= '0;
      end

      // Restoring division: one quotient bit per clock, dividend MSB first.
      if (state_reg == DIV) begin
        rem_reg  <= rem_next;
        quo_reg  <= {quo_reg[N-1:0], q_bit};
        dvd_reg  <= {dvd_reg[N-1:0], 1'b0};
        iter_reg <= iter_reg + IW'(1);
      end

      if (timeout) begin
        freq_out  <= '0;
        valid     <= 1'b1;
        locked    <= 1'b0;
        first_reg <= 1'b1;
      end else if (state_reg == DONE) begin
        freq_out <= freq_sat;
        valid    <= 1'b1;
        locked   <= 1'b1;
      end
    end
  end

endmodule
